tuner_phy_ctrl_arb_mc: RTL and testbench
========================================

Name: tuner_phy_ctrl_arb_mc

Overview:
Multi-channel controller arbiter for the tuner PHY. It generalises the two-channel (search/lock) tune/sync/commit arbiter to NUM_CH controller channels, with selectable fixed-priority or round-robin arbitration. It applies the granted channel's tuner code and waits a runtime-programmable settle time. It then captures the power-detect sample, with timeout, and returns it to the granted channel. It sits between the per-channel search/lock controllers and the shared tuner DAC / power-detect path.

Parameters:
NUM_CH, 2, number of controller channels (>=2); channel 0 = search, channel 1 = lock by convention.
CODE_WIDTH, 8, tuner code width.
PWR_WIDTH, 8, power-detect sample width.
SYNC_CNT_WIDTH, 8, width of the settle-length input and its counter.
TIMEOUT_CYCLES, 256, maximum cycles to wait for i_pwr_valid after settle expiry (>=1).
ARB_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round robin.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_ch_req  in  NUM_CH  per-channel request, level
i_ch_code  in  NUM_CH*CODE_WIDTH  per-channel tuner code, channel k at bits [k*CODE_WIDTH +: CODE_WIDTH]
i_sync_len  in  SYNC_CNT_WIDTH  settle cycles after code apply
i_pwr  in  PWR_WIDTH  power-detect sample
i_pwr_valid  in  1  sample valid strobe
o_ch_gnt  out  NUM_CH  one-hot grant, held for TUNE through COMMIT
o_ch_commit  out  NUM_CH  one-cycle one-hot commit pulse
o_ch_pwr  out  PWR_WIDTH  captured sample, valid with commit
o_ch_err  out  1  timeout flag, valid with commit
o_tuner_code  out  CODE_WIDTH  code driven to tuner, holds last applied value
o_tuner_valid  out  1  one-cycle apply strobe
o_state  out  2  INIT=00, TUNE=01, SYNC=10, COMMIT=11

Behaviour:
- Clock and reset: single clock domain; reset is synchronous, active-high.
- Reset value of every output is 0, and state is INIT.
  - Round-robin pointer resets to 0.
  - Reset takes effect from any state, including mid-SYNC.
  - No commit is issued for an aborted transaction.
  - o_tuner_code returns to 0.
- INIT:
  - If no request is asserted, remain in INIT.
  - If any i_ch_req is asserted, select winner W and latch W and i_ch_code[W] this cycle; next state is TUNE.
  - Requests are sampled only in INIT.
- Arbitration:
  - ARB_MODE=0: lowest asserted index wins.
  - ARB_MODE=1: first asserted index at or after the pointer, wrapping NUM_CH-1 to 0.
  - Pointer updates to (W+1) mod NUM_CH on the COMMIT cycle only.
- TUNE (1 cycle):
  - o_tuner_code = latched code; o_tuner_valid = 1; o_ch_gnt[W] = 1.
  - Latch i_sync_len into the settle counter; next state is SYNC.
- SYNC:
  - Counter decrements once per cycle until 0.
  - i_pwr_valid is ignored while counter > 0.
  - Once counter == 0, the first cycle with i_pwr_valid=1 captures i_pwr, clears the error flag, and moves to COMMIT.
  - i_sync_len = 0 means capture is possible on the first SYNC cycle.
  - Timeout counter starts when the settle counter reaches 0. If TIMEOUT_CYCLES cycles elapse with no valid sample, set the error flag, capture 0, and move to COMMIT.
- COMMIT (1 cycle):
  - o_ch_commit[W] = 1, with o_ch_pwr and o_ch_err valid.
  - Grant deasserts the next cycle; next state is INIT.
  - A new grant is therefore at least 2 cycles after commit.
- o_ch_pwr and o_ch_err hold their values until the next COMMIT.
- Latency: request seen in INIT at cycle t, settle length L, sample arriving exactly at expiry:
  - TUNE at t+1, SYNC t+2 .. t+2+L, COMMIT t+3+L.
- A request dropped mid-transaction does not abort it; the commit is still issued to W.
- i_ch_code changes after latch do not affect o_tuner_code.
- Simultaneous requests are resolved by ARB_MODE. A requester losing in INIT keeps requesting and is re-evaluated in the next INIT.

Test Plan:
- NUM_CH=2, only ch1 requests with code 0x5A, i_sync_len=3, i_pwr_valid with i_pwr=0x77 at first eligible cycle -> o_tuner_valid at t+1 with code 0x5A; o_ch_commit=2'b10 at t+6 with o_ch_pwr=0x77 and o_ch_err=0.
- ARB_MODE=0, NUM_CH=4, all channels request continuously for 4 transactions -> every grant is 4'b0001.
- ARB_MODE=1, NUM_CH=4, all channels request continuously -> grants are 0001, 0010, 0100, 1000, 0001; then ch2 drops its request -> order skips ch2.
- i_sync_len=0 with i_pwr_valid held high -> COMMIT at t+3; with i_sync_len=5, a pulse 2 cycles into SYNC is ignored and a later pulse is captured.
- TIMEOUT_CYCLES=8, i_pwr_valid never asserted -> COMMIT exactly 8 cycles after settle expiry with o_ch_err=1 and o_ch_pwr=0; the next transaction clears o_ch_err.
- rst asserted mid-SYNC -> next cycle all outputs 0, o_state=00, no commit pulse, round-robin pointer back to 0.

Source files
------------

// File: rtl/tuner_phy_ctrl_arb_mc.sv
// rtl/tuner_phy_ctrl_arb_mc.sv - multi-channel tune/sync/commit arbiter for the tuner PHY
//
// Purpose:
//   Arbitrates NUM_CH controller channels (ch0 = search, ch1 = lock by
//   convention) onto the shared tuner DAC and power-detect path. A granted
//   channel's code is applied for one cycle and then a programmable settle
//   time elapses. After that, the first valid power sample is captured and
//   returned, or an error is flagged on timeout. Either way the transaction
//   completes with a one-cycle commit pulse to the granted channel.
//
// Ports:
//   clk            clock
//   rst            synchronous active-high reset
//   i_ch_req       per-channel level request, sampled only in INIT
//   i_ch_code      packed per-channel tuner codes, ch k at [k*CODE_WIDTH +: CODE_WIDTH]
//   i_sync_len     settle cycles after code apply, latched in TUNE
//   i_pwr          power-detect sample
//   i_pwr_valid    power-detect sample strobe
//   o_ch_gnt       one-hot grant, held TUNE through COMMIT
//   o_ch_commit    one-cycle one-hot commit pulse
//   o_ch_pwr       captured sample, valid with commit, held until next commit
//   o_ch_err       timeout flag, valid with commit, held until next commit
//   o_tuner_code   code driven to the tuner, holds last applied value
//   o_tuner_valid  one-cycle apply strobe (TUNE)
//   o_state        INIT=00, TUNE=01, SYNC=10, COMMIT=11

module tuner_phy_ctrl_arb_mc #(
    parameter int NUM_CH         = 2,
    parameter int CODE_WIDTH     = 8,
    parameter int PWR_WIDTH      = 8,
    parameter int SYNC_CNT_WIDTH = 8,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int ARB_MODE       = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            i_ch_req,
    input  logic [NUM_CH*CODE_WIDTH-1:0] i_ch_code,
    input  logic [SYNC_CNT_WIDTH-1:0]    i_sync_len,
    input  logic [PWR_WIDTH-1:0]         i_pwr,
    input  logic                         i_pwr_valid,
    output logic [NUM_CH-1:0]            o_ch_gnt,
    output logic [NUM_CH-1:0]            o_ch_commit,
    output logic [PWR_WIDTH-1:0]         o_ch_pwr,
    output logic                         o_ch_err,
    output logic [CODE_WIDTH-1:0]        o_tuner_code,
    output logic                         o_tuner_valid,
    output logic [1:0]                   o_state
);

    localparam int IDX_W = $clog2(NUM_CH);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_INIT   = 2'b00,
        ST_TUNE   = 2'b01,
        ST_SYNC   = 2'b10,
        ST_COMMIT = 2'b11
    } state_t;

    state_t                    state;
    logic [IDX_W-1:0]          rr_ptr;
    logic [IDX_W-1:0]          gnt_idx;
    logic [SYNC_CNT_WIDTH-1:0] settle_cnt;
    logic [TO_W-1:0]           to_cnt;

    // Arbitration: requests at or above the round-robin pointer are tried
    // first; if none exist the search wraps to the lowest asserted index.
    // In fixed-priority mode every request counts as "upper", so the lowest
    // asserted index always wins.
    logic [NUM_CH-1:0]     upper_req;
    logic                  upper_any;
    logic [IDX_W-1:0]      upper_idx;
    logic [IDX_W-1:0]      any_idx;
    logic [IDX_W-1:0]      win_idx;
    logic [NUM_CH-1:0]     win_onehot;
    logic [CODE_WIDTH-1:0] win_code;

    always_comb begin
        upper_req  = '0;
        upper_any  = 1'b0;
        upper_idx  = '0;
        any_idx    = '0;
        win_idx    = '0;
        win_onehot = '0;
        win_code   = '0;

        for (int i = 0; i < NUM_CH; i++) begin
            upper_req[i] = i_ch_req[i] && ((ARB_MODE == 0) || (i >= int'(rr_ptr)));
        end

        // Descending scan so the lowest qualifying index is the last written.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (upper_req[i]) begin
                upper_idx = IDX_W'(i);
                upper_any = 1'b1;
            end
            if (i_ch_req[i]) begin
                any_idx = IDX_W'(i);
            end
        end

        win_idx = upper_any ? upper_idx : any_idx;

        for (int i = 0; i < NUM_CH; i++) begin
            if (IDX_W'(i) == win_idx) begin
                win_onehot[i] = 1'b1;
                win_code      = i_ch_code[i*CODE_WIDTH +: CODE_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_INIT;
            rr_ptr        <= '0;
            gnt_idx       <= '0;
            settle_cnt    <= '0;
            to_cnt        <= '0;
            o_ch_gnt      <= '0;
            o_ch_commit   <= '0;
            o_ch_pwr      <= '0;
            o_ch_err      <= 1'b0;
            o_tuner_code  <= '0;
            o_tuner_valid <= 1'b0;
        end else begin
            o_tuner_valid <= 1'b0;
            o_ch_commit   <= '0;

            case (state)
                ST_INIT: begin
                    // Winner and its code are frozen here; later changes
                    // to i_ch_req / i_ch_code do not affect this transaction.
                    if (|i_ch_req) begin
                        gnt_idx       <= win_idx;
                        o_ch_gnt      <= win_onehot;
                        o_tuner_code  <= win_code;
                        o_tuner_valid <= 1'b1;
                        state         <= ST_TUNE;
                    end
                end

                ST_TUNE: begin
                    settle_cnt <= i_sync_len;
                    to_cnt     <= '0;
                    state      <= ST_SYNC;
                end

                ST_SYNC: begin
                    if (settle_cnt != '0) begin
                        // Still settling: samples are ignored.
                        settle_cnt <= settle_cnt - SYNC_CNT_WIDTH'(1);
                    end else if (i_pwr_valid) begin
                        o_ch_pwr    <= i_pwr;
                        o_ch_err    <= 1'b0;
                        o_ch_commit <= o_ch_gnt;
                        state       <= ST_COMMIT;
                    end else if (to_cnt == TO_LAST) begin
                        // TIMEOUT_CYCLES sample-eligible cycles without a sample.
                        o_ch_pwr    <= '0;
                        o_ch_err    <= 1'b1;
                        o_ch_commit <= o_ch_gnt;
                        state       <= ST_COMMIT;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end

                ST_COMMIT: begin
                    o_ch_gnt <= '0;
                    rr_ptr   <= (gnt_idx == IDX_LAST) ? '0 : gnt_idx + IDX_W'(1);
                    state    <= ST_INIT;
                end

                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

    assign o_state = state;

endmodule

// File: tb/tb_tuner_phy_ctrl_arb_mc.sv
// tb/tb_tuner_phy_ctrl_arb_mc.sv - directed self-checking bench for tuner_phy_ctrl_arb_mc

module tb_tuner_phy_ctrl_arb_mc;

    logic       clk;
    logic       rst;
    logic [7:0] sync_len;
    logic [7:0] pwr;
    logic       pwr_valid;

    // Two-channel instance, round robin, default timeout
    logic [1:0]  req2, gnt2, com2, st2;
    logic [15:0] code2;
    logic [7:0]  pwr2, tc2;
    logic        err2, tv2;

    // Four-channel fixed priority, timeout 8
    logic [3:0]  reqp, gntp, comp;
    logic [1:0]  stp;
    logic [31:0] codep;
    logic [7:0]  pwrp, tcp;
    logic        errp, tvp;

    // Four-channel round robin, timeout 8
    logic [3:0]  reqr, gntr, comr;
    logic [1:0]  str;
    logic [31:0] coder;
    logic [7:0]  pwrr, tcr;
    logic        errr, tvr;

    int n_checks;
    int n_fail;

    tuner_phy_ctrl_arb_mc #(.NUM_CH(2), .TIMEOUT_CYCLES(256), .ARB_MODE(1)) dut2 (
        .clk(clk), .rst(rst), .i_ch_req(req2), .i_ch_code(code2), .i_sync_len(sync_len),
        .i_pwr(pwr), .i_pwr_valid(pwr_valid), .o_ch_gnt(gnt2), .o_ch_commit(com2),
        .o_ch_pwr(pwr2), .o_ch_err(err2), .o_tuner_code(tc2), .o_tuner_valid(tv2), .o_state(st2)
    );

    tuner_phy_ctrl_arb_mc #(.NUM_CH(4), .TIMEOUT_CYCLES(8), .ARB_MODE(0)) dutp (
        .clk(clk), .rst(rst), .i_ch_req(reqp), .i_ch_code(codep), .i_sync_len(sync_len),
        .i_pwr(pwr), .i_pwr_valid(pwr_valid), .o_ch_gnt(gntp), .o_ch_commit(comp),
        .o_ch_pwr(pwrp), .o_ch_err(errp), .o_tuner_code(tcp), .o_tuner_valid(tvp), .o_state(stp)
    );

    tuner_phy_ctrl_arb_mc #(.NUM_CH(4), .TIMEOUT_CYCLES(8), .ARB_MODE(1)) dutr (
        .clk(clk), .rst(rst), .i_ch_req(reqr), .i_ch_code(coder), .i_sync_len(sync_len),
        .i_pwr(pwr), .i_pwr_valid(pwr_valid), .o_ch_gnt(gntr), .o_ch_commit(comr),
        .o_ch_pwr(pwrr), .o_ch_err(errr), .o_tuner_code(tcr), .o_tuner_valid(tvr), .o_state(str)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        n_checks++; if (st2 !== 2'b00) begin n_fail++; $display("FAIL reset_state2 got=%b exp=00", st2); end
        n_checks++; if (gnt2 !== 2'b00 || com2 !== 2'b00) begin n_fail++; $display("FAIL reset_gnt_commit2 got=%b/%b exp=00/00", gnt2, com2); end
        n_checks++; if (tc2 !== 8'h00 || tv2 !== 1'b0) begin n_fail++; $display("FAIL reset_tuner2 got=%h/%b exp=00/0", tc2, tv2); end
        n_checks++; if (pwr2 !== 8'h00 || err2 !== 1'b0) begin n_fail++; $display("FAIL reset_pwr_err2 got=%h/%b exp=00/0", pwr2, err2); end
        n_checks++; if (stp !== 2'b00 || gntp !== 4'h0) begin n_fail++; $display("FAIL reset_p got=%b/%b exp=00/0000", stp, gntp); end
        n_checks++; if (str !== 2'b00 || comr !== 4'h0) begin n_fail++; $display("FAIL reset_r got=%b/%b exp=00/0000", str, comr); end
        rst = 1'b0;
    endtask

    task automatic test_single;
        code2     = {8'h5A, 8'h00};
        req2      = 2'b10;
        sync_len  = 8'd3;
        pwr_valid = 1'b0;
        pwr       = 8'h77;
        tick(); // t+1
        n_checks++; if (st2 !== 2'b01) begin n_fail++; $display("FAIL single_tune_state got=%b exp=01", st2); end
        n_checks++; if (tv2 !== 1'b1 || tc2 !== 8'h5A) begin n_fail++; $display("FAIL single_apply got=%b/%h exp=1/5a", tv2, tc2); end
        n_checks++; if (gnt2 !== 2'b10) begin n_fail++; $display("FAIL single_gnt got=%b exp=10", gnt2); end
        req2  = 2'b00;
        code2 = 16'hFFFF;
        for (int c = 2; c <= 5; c++) begin
            tick();
            n_checks++; if (st2 !== 2'b10 || com2 !== 2'b00) begin n_fail++; $display("FAIL single_sync_c%0d got=%b/%b exp=10/00", c, st2, com2); end
        end
        n_checks++; if (tc2 !== 8'h5A || tv2 !== 1'b0) begin n_fail++; $display("FAIL single_code_hold got=%h/%b exp=5a/0", tc2, tv2); end
        pwr_valid = 1'b1;
        tick(); // t+6
        pwr_valid = 1'b0;
        n_checks++; if (com2 !== 2'b10 || st2 !== 2'b11) begin n_fail++; $display("FAIL single_commit got=%b/%b exp=10/11", com2, st2); end
        n_checks++; if (pwr2 !== 8'h77 || err2 !== 1'b0) begin n_fail++; $display("FAIL single_pwr got=%h/%b exp=77/0", pwr2, err2); end
        tick(); // t+7
        n_checks++; if (st2 !== 2'b00 || gnt2 !== 2'b00 || com2 !== 2'b00) begin n_fail++; $display("FAIL single_after got=%b/%b/%b exp=00/00/00", st2, gnt2, com2); end
        n_checks++; if (pwr2 !== 8'h77) begin n_fail++; $display("FAIL single_pwr_hold got=%h exp=77", pwr2); end
    endtask

    task automatic test_fixed_priority;
        int n;
        codep     = 32'hD4C3B2A1;
        reqp      = 4'hF;
        sync_len  = 8'd0;
        pwr_valid = 1'b1;
        pwr       = 8'h3C;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (tvp !== 1'b1 && n < 20) begin tick(); n++; end
            n_checks++; if (gntp !== 4'b0001 || tcp !== 8'hA1) begin n_fail++; $display("FAIL fixed_gnt_%0d got=%b/%h exp=0001/a1", k, gntp, tcp); end
            n = 0;
            while (comp === 4'b0000 && n < 20) begin tick(); n++; end
            n_checks++; if (comp !== 4'b0001) begin n_fail++; $display("FAIL fixed_commit_%0d got=%b exp=0001", k, comp); end
        end
        reqp = 4'h0;
        tick();
    endtask

    task automatic test_round_robin;
        int n;
        int exp_ch [8] = '{0, 1, 2, 3, 0, 1, 3, 0};
        logic [3:0] egnt;
        logic [7:0] ecode;
        coder     = 32'h44332211;
        reqr      = 4'hF;
        sync_len  = 8'd0;
        pwr_valid = 1'b1;
        pwr       = 8'h3C;
        for (int k = 0; k < 8; k++) begin
            egnt  = 4'b0001 << exp_ch[k];
            ecode = 8'((exp_ch[k] + 1) * 17);
            n = 0;
            while (tvr !== 1'b1 && n < 20) begin tick(); n++; end
            n_checks++; if (gntr !== egnt || tcr !== ecode) begin n_fail++; $display("FAIL rr_gnt_%0d got=%b/%h exp=%b/%h", k, gntr, tcr, egnt, ecode); end
            if (k == 4) reqr = 4'b1011;
            n = 0;
            while (comr === 4'b0000 && n < 20) begin tick(); n++; end
            n_checks++; if (comr !== egnt || pwrr !== 8'h3C || errr !== 1'b0) begin n_fail++; $display("FAIL rr_commit_%0d got=%b/%h/%b exp=%b/3c/0", k, comr, pwrr, errr, egnt); end
        end
        reqr = 4'h0;
        tick();
    endtask

    task automatic test_sync_len;
        // L = 0 with valid held high: COMMIT at t+3
        code2     = {8'h00, 8'h33};
        req2      = 2'b01;
        sync_len  = 8'd0;
        pwr_valid = 1'b1;
        pwr       = 8'h11;
        tick(); // t+1
        req2 = 2'b00;
        n_checks++; if (st2 !== 2'b01 || tc2 !== 8'h33) begin n_fail++; $display("FAIL len0_tune got=%b/%h exp=01/33", st2, tc2); end
        tick(); // t+2
        n_checks++; if (st2 !== 2'b10) begin n_fail++; $display("FAIL len0_sync got=%b exp=10", st2); end
        tick(); // t+3
        n_checks++; if (com2 !== 2'b01 || pwr2 !== 8'h11) begin n_fail++; $display("FAIL len0_commit got=%b/%h exp=01/11", com2, pwr2); end
        pwr_valid = 1'b0;
        tick();
        // L = 5: early pulse ignored, later pulse captured
        req2     = 2'b01;
        sync_len = 8'd5;
        tick(); // t+1
        req2 = 2'b00;
        tick(); // t+2
        tick(); // t+3
        tick(); // t+4
        pwr_valid = 1'b1;
        pwr       = 8'hEE;
        tick(); // t+5
        pwr_valid = 1'b0;
        n_checks++; if (st2 !== 2'b10 || com2 !== 2'b00) begin n_fail++; $display("FAIL len5_early_ignored got=%b/%b exp=10/00", st2, com2); end
        for (int c = 6; c <= 9; c++) begin
            tick();
            n_checks++; if (st2 !== 2'b10) begin n_fail++; $display("FAIL len5_sync_c%0d got=%b exp=10", c, st2); end
        end
        pwr_valid = 1'b1;
        pwr       = 8'h42;
        tick(); // t+10
        pwr_valid = 1'b0;
        n_checks++; if (com2 !== 2'b01 || pwr2 !== 8'h42 || err2 !== 1'b0) begin n_fail++; $display("FAIL len5_commit got=%b/%h/%b exp=01/42/0", com2, pwr2, err2); end
        tick();
    endtask

    task automatic test_timeout;
        reqr      = 4'b0100;
        sync_len  = 8'd2;
        pwr_valid = 1'b0;
        tick(); // t+1
        reqr = 4'h0;
        n_checks++; if (str !== 2'b01 || gntr !== 4'b0100) begin n_fail++; $display("FAIL to_tune got=%b/%b exp=01/0100", str, gntr); end
        for (int c = 2; c <= 11; c++) begin
            tick();
            n_checks++; if (str !== 2'b10 || comr !== 4'h0) begin n_fail++; $display("FAIL to_wait_c%0d got=%b/%b exp=10/0000", c, str, comr); end
        end
        tick(); // t+12 = settle expiry (t+4) + 8
        n_checks++; if (comr !== 4'b0100 || errr !== 1'b1 || pwrr !== 8'h00) begin n_fail++; $display("FAIL to_commit got=%b/%b/%h exp=0100/1/00", comr, errr, pwrr); end
        tick();
        n_checks++; if (errr !== 1'b1 || str !== 2'b00) begin n_fail++; $display("FAIL to_err_hold got=%b/%b exp=1/00", errr, str); end
        reqr      = 4'b0100;
        sync_len  = 8'd0;
        pwr_valid = 1'b1;
        pwr       = 8'h99;
        tick();
        reqr = 4'h0;
        tick();
        tick();
        n_checks++; if (comr !== 4'b0100 || errr !== 1'b0 || pwrr !== 8'h99) begin n_fail++; $display("FAIL to_clear got=%b/%b/%h exp=0100/0/99", comr, errr, pwrr); end
        pwr_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid;
        int n;
        reqr      = 4'hF;
        sync_len  = 8'd10;
        pwr_valid = 1'b0;
        tick();
        // pointer is 3 after the ch2 commit
        n_checks++; if (gntr !== 4'b1000) begin n_fail++; $display("FAIL rst_pre_gnt got=%b exp=1000", gntr); end
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        n_checks++; if (str !== 2'b00 || gntr !== 4'h0 || comr !== 4'h0) begin n_fail++; $display("FAIL rst_mid_ctrl got=%b/%b/%b exp=00/0000/0000", str, gntr, comr); end
        n_checks++; if (tcr !== 8'h00 || tvr !== 1'b0 || pwrr !== 8'h00 || errr !== 1'b0) begin n_fail++; $display("FAIL rst_mid_data got=%h/%b/%h/%b exp=00/0/00/0", tcr, tvr, pwrr, errr); end
        rst = 1'b0;
        tick();
        n_checks++; if (gntr !== 4'b0001 || str !== 2'b01) begin n_fail++; $display("FAIL rst_ptr got=%b/%b exp=0001/01", gntr, str); end
        reqr      = 4'h0;
        sync_len  = 8'd0;
        pwr_valid = 1'b1;
        pwr       = 8'h5C;
        n = 0;
        while (comr === 4'b0000 && n < 20) begin tick(); n++; end
        n_checks++; if (comr !== 4'b0001 || pwrr !== 8'h5C) begin n_fail++; $display("FAIL rst_post_commit got=%b/%h exp=0001/5c", comr, pwrr); end
        pwr_valid = 1'b0;
        tick();
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        sync_len  = 8'd0;
        pwr       = 8'h00;
        pwr_valid = 1'b0;
        req2      = 2'b00;
        code2     = 16'h0000;
        reqp      = 4'h0;
        codep     = 32'h0;
        reqr      = 4'h0;
        coder     = 32'h0;

        test_reset();
        test_single();
        test_fixed_priority();
        test_round_robin();
        test_sync_len();
        test_timeout();
        test_reset_mid();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
